// File: rtl/timer_array.sv
// Bank of N_CH memory-mapped programmable timers with per-channel and ORed interrupts.
// Optional build macro TIMER_ARRAY_CASCADE_EN lets channel i>=1 count channel i-1 overflows.
module timer_array #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PSC_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Address,
    input  logic [31:0]     Write_data,
    input  logic            MemWrite,
    input  logic            MemRead,
    output logic [31:0]     Read_data,
    output logic [N_CH-1:0] irq_vec,
    output logic            irq
);

    localparam logic [31:2] SPAN_WORDS = 30'(4 * N_CH);

    logic [WIDTH-1:0] th_q   [N_CH];
    logic [WIDTH-1:0] th_d   [N_CH];
    logic [WIDTH-1:0] tl_q   [N_CH];
    logic [WIDTH-1:0] tl_d   [N_CH];
    logic [PSC_W-1:0] psc_q  [N_CH];
    logic [PSC_W-1:0] psc_d  [N_CH];
    logic [PSC_W-1:0] pcnt_q [N_CH];
    logic [PSC_W-1:0] pcnt_d [N_CH];
    logic [N_CH-1:0]  en_q, en_d, ie_q, ie_d, pend_q, pend_d, os_q, os_d;
    logic [N_CH-1:0]  cascRd;

    logic [31:2] wordOff;
    logic        inRange;
    logic        hit;
    logic        tick;
    logic        ovf;
    logic        unusedAddrBits;

`ifdef TIMER_ARRAY_CASCADE_EN
    logic [N_CH-1:0] casc_q, casc_d;
    logic            prevOvf;
    assign cascRd = casc_q;
`else
    assign cascRd = '0;
`endif

    // Word offset keeps byte-address bit numbering: [7:4] channel, [3:2] register.
    assign wordOff        = Address[31:2] - BASE_ADDR[31:2];
    assign inRange        = (wordOff < SPAN_WORDS);
    assign unusedAddrBits = ^Address[1:0];

    assign irq_vec = pend_q & ie_q;
    assign irq     = |irq_vec;

    always_comb begin
        en_d   = en_q;
        ie_d   = ie_q;
        pend_d = pend_q;
        os_d   = os_q;
        hit    = 1'b0;
        tick   = 1'b0;
        ovf    = 1'b0;
`ifdef TIMER_ARRAY_CASCADE_EN
        casc_d  = casc_q;
        prevOvf = 1'b0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            th_d[i]   = th_q[i];
            tl_d[i]   = tl_q[i];
            psc_d[i]  = psc_q[i];
            hit       = MemWrite && inRange && (wordOff[7:4] == 4'(i));
            tick      = en_q[i] && (pcnt_q[i] == psc_q[i]);
            pcnt_d[i] = (!en_q[i] || (pcnt_q[i] == psc_q[i])) ? '0 : pcnt_q[i] + PSC_W'(1);
`ifdef TIMER_ARRAY_CASCADE_EN
            if ((i != 0) && casc_q[i] && en_q[i]) begin
                tick = prevOvf;
            end
`endif
            ovf = tick && (tl_q[i] == '1);
`ifdef TIMER_ARRAY_CASCADE_EN
            prevOvf = ovf;
`endif
            if (tick) begin
                if (ovf) begin
                    tl_d[i] = th_q[i];
                    if (os_q[i]) begin
                        en_d[i] = 1'b0;
                    end
                end else begin
                    tl_d[i] = tl_q[i] + WIDTH'(1);
                end
            end
            // CPU writes override the tick update, except that overflow still sets pending.
            if (hit) begin
                case (wordOff[3:2])
                    2'd0: th_d[i] = Write_data[WIDTH-1:0];
                    2'd1: tl_d[i] = Write_data[WIDTH-1:0];
                    2'd2: begin
                        en_d[i] = Write_data[0];
                        ie_d[i] = Write_data[1];
                        if (Write_data[2]) begin
                            pend_d[i] = 1'b0;
                        end
                        os_d[i]   = Write_data[3];
`ifdef TIMER_ARRAY_CASCADE_EN
                        casc_d[i] = Write_data[4];
`endif
                        pcnt_d[i] = '0;
                    end
                    default: begin
                        psc_d[i]  = Write_data[PSC_W-1:0];
                        pcnt_d[i] = '0;
                    end
                endcase
            end
            if (ovf) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                th_q[i]   <= '0;
                tl_q[i]   <= '0;
                psc_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
            en_q   <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            os_q   <= '0;
`ifdef TIMER_ARRAY_CASCADE_EN
            casc_q <= '0;
`endif
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            pend_q <= pend_d;
            os_q   <= os_d;
`ifdef TIMER_ARRAY_CASCADE_EN
            casc_q <= casc_d;
`endif
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead && inRange) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wordOff[7:4] == 4'(i)) begin
                    case (wordOff[3:2])
                        2'd0:    Read_data = 32'(th_q[i]);
                        2'd1:    Read_data = 32'(tl_q[i]);
                        2'd2:    Read_data = {27'd0, cascRd[i], os_q[i], pend_q[i], ie_q[i], en_q[i]};
                        default: Read_data = 32'(psc_q[i]);
                    endcase
                end
            end
        end
    end

endmodule
